// File: rtl/hls_deadlock_monitor_param.sv
// hls_deadlock_monitor_param
// Watches an HLS dataflow region and flags a deadlock. A deadlock is declared
// when at least one process is stalled on an AXI-Stream channel and every
// process is idle, blocked on an internal channel, or blocked on a stream.
// The condition must hold for HOLD_CYCLES consecutive cycles before it is
// reported. The first detection is latched with a timestamp until clear.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   axis_block_sigs       : per-channel stream-blocked flags
//   proc_idle_sigs        : per-process idle
//   proc_chan_block_sigs  : per-process internal FIFO/channel block
//   axis_proc_map         : row p (NUM_AXIS bits) = channels owned by process p
//   axis_mask             : 1 = ignore channel
//   clear                 : pulse, drops sticky state and captured fields
//   block                 : live flag, detected and condition still present
//   block_sticky          : detection latched until clear/reset
//   axis_block_info       : masked stream-block flags captured at detection
//   first_axis_idx        : lowest set index of axis_block_info
//   detect_time           : timestamp of the final condition cycle
//   detect_count          : detections since reset, saturating at 255
//
// State table
//   MONITOR  | condition not present, hold counter at 0
//   PENDING  | condition present, counting consecutive cycles in hc_q
//   DETECTED | detection latched, left only by clear or reset
module hls_deadlock_monitor_param #(
  parameter int NUM_PROC    = 2,
  parameter int NUM_AXIS    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int TS_W        = 32,
  localparam int IDX_W      = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_AXIS-1:0]          axis_block_sigs,
  input  logic [NUM_PROC-1:0]          proc_idle_sigs,
  input  logic [NUM_PROC-1:0]          proc_chan_block_sigs,
  input  logic [NUM_PROC*NUM_AXIS-1:0] axis_proc_map,
  input  logic [NUM_AXIS-1:0]          axis_mask,
  input  logic                         clear,
  output logic                         block,
  output logic                         block_sticky,
  output logic [NUM_AXIS-1:0]          axis_block_info,
  output logic [IDX_W-1:0]             first_axis_idx,
  output logic [TS_W-1:0]              detect_time,
  output logic [7:0]                   detect_count
);

  typedef enum logic [1:0] {
    MONITOR  = 2'd0,
    PENDING  = 2'd1,
    DETECTED = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t               state_q, state_d;
  logic [15:0]          hc_q, hc_d;
  logic [TS_W-1:0]      ts_q;
  logic                 block_q;
  logic [NUM_AXIS-1:0]  info_q;
  logic [IDX_W-1:0]     idx_q;
  logic [TS_W-1:0]      time_q;
  logic [7:0]           count_q;

  logic [NUM_AXIS-1:0]  eff;
  logic [NUM_PROC-1:0]  pax;
  logic [NUM_PROC-1:0]  stop;
  logic                 cond;
  logic [IDX_W-1:0]     low_idx;
  logic                 detect_now;

  always_comb begin
    eff = axis_block_sigs & ~axis_mask;
    for (int p = 0; p < NUM_PROC; p++) begin
      pax[p] = |(eff & axis_proc_map[p*NUM_AXIS +: NUM_AXIS]);
    end
    stop = proc_idle_sigs | proc_chan_block_sigs | pax;
    cond = (|pax) & (&stop);
  end

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int a = NUM_AXIS - 1; a >= 0; a--) begin
      if (eff[a]) low_idx = IDX_W'(a);
    end
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    if (clear) begin
      state_d = MONITOR;
      hc_d    = '0;
    end else begin
      case (state_q)
        MONITOR: begin
          if (cond && (HOLD_CYCLES == 1)) begin
            state_d = DETECTED;
            hc_d    = '0;
          end else if (cond) begin
            state_d = PENDING;
            hc_d    = 16'd1;
          end else begin
            hc_d    = '0;
          end
        end
        PENDING: begin
          if (!cond) begin
            state_d = MONITOR;
            hc_d    = '0;
          end else if (hc_q == HOLD_LAST) begin
            state_d = DETECTED;
            hc_d    = '0;
          end else begin
            hc_d    = hc_q + 16'd1;
          end
        end
        DETECTED: begin
          state_d = DETECTED;
        end
        default: begin
          state_d = MONITOR;
          hc_d    = '0;
        end
      endcase
    end
  end

  // clear already forces MONITOR, so it can never produce a detection edge.
  assign detect_now = (state_q != DETECTED) && (state_d == DETECTED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MONITOR;
      hc_q    <= '0;
      ts_q    <= '0;
      block_q <= 1'b0;
      info_q  <= '0;
      idx_q   <= '0;
      time_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      ts_q    <= ts_q + 1'b1;
      block_q <= (state_d == DETECTED) && cond;
      if (clear) begin
        info_q <= '0;
        idx_q  <= '0;
        time_q <= '0;
      end else if (detect_now) begin
        info_q <= eff;
        idx_q  <= low_idx;
        time_q <= ts_q;
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      end
    end
  end

  assign block           = block_q;
  assign block_sticky    = (state_q == DETECTED);
  assign axis_block_info = info_q;
  assign first_axis_idx  = idx_q;
  assign detect_time     = time_q;
  assign detect_count    = count_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Bench for hls_deadlock_monitor_param: one instance with HOLD_CYCLES=16 and
// one with HOLD_CYCLES=1, driven by the same stimulus and compared against a
// run-length reference model after every clock edge.
module tb_hls_deadlock_monitor_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] axis_block_sigs;
  logic [1:0] proc_idle_sigs;
  logic [1:0] proc_chan_block_sigs;
  logic [5:0] axis_proc_map;
  logic [2:0] axis_mask;
  logic       clear;

  logic        blk_o    [2];
  logic        sticky_o [2];
  logic [2:0]  info_o   [2];
  logic [1:0]  idx_o    [2];
  logic [31:0] dtime_o  [2];
  logic [7:0]  cnt_o    [2];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hls_deadlock_monitor_param #(.NUM_PROC(2), .NUM_AXIS(3), .HOLD_CYCLES(16), .TS_W(32)) dut_h16 (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_block_sigs), .proc_idle_sigs(proc_idle_sigs),
    .proc_chan_block_sigs(proc_chan_block_sigs), .axis_proc_map(axis_proc_map),
    .axis_mask(axis_mask), .clear(clear),
    .block(blk_o[0]), .block_sticky(sticky_o[0]), .axis_block_info(info_o[0]),
    .first_axis_idx(idx_o[0]), .detect_time(dtime_o[0]), .detect_count(cnt_o[0])
  );

  hls_deadlock_monitor_param #(.NUM_PROC(2), .NUM_AXIS(3), .HOLD_CYCLES(1), .TS_W(32)) dut_h1 (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_block_sigs), .proc_idle_sigs(proc_idle_sigs),
    .proc_chan_block_sigs(proc_chan_block_sigs), .axis_proc_map(axis_proc_map),
    .axis_mask(axis_mask), .clear(clear),
    .block(blk_o[1]), .block_sticky(sticky_o[1]), .axis_block_info(info_o[1]),
    .first_axis_idx(idx_o[1]), .detect_time(dtime_o[1]), .detect_count(cnt_o[1])
  );

  // Reference model: counts consecutive deadlock cycles per instance.
  int          hold_m [2] = '{16, 1};
  int          run_m  [2];
  bit          det_m  [2];
  bit          blk_m  [2];
  logic [2:0]  info_m [2];
  logic [1:0]  idx_m  [2];
  logic [31:0] time_m [2];
  int          cnt_m  [2];
  logic [31:0] ts_m;

  function automatic logic [2:0] eff_f();
    return axis_block_sigs & ~axis_mask;
  endfunction

  // Deadlock: some process waits on a live stream and every process is stopped.
  function automatic bit cond_f();
    logic [2:0] e = eff_f();
    int on_stream = 0;
    int stopped   = 0;
    for (int p = 0; p < 2; p++) begin
      bit s = 0;
      for (int a = 0; a < 3; a++) if (e[a] && axis_proc_map[p*3 + a]) s = 1;
      if (s) on_stream++;
      if (s || proc_idle_sigs[p] || proc_chan_block_sigs[p]) stopped++;
    end
    return (on_stream > 0) && (stopped == 2);
  endfunction

  function automatic logic [1:0] lowest_f(input logic [2:0] v);
    for (int a = 0; a < 3; a++) if (v[a]) return 2'(a);
    return 2'd0;
  endfunction

  task automatic model_edge(input bit c, input logic [2:0] e);
    if (reset) begin
      ts_m = 0;
      for (int i = 0; i < 2; i++) begin
        run_m[i] = 0; det_m[i] = 0; blk_m[i] = 0;
        info_m[i] = 0; idx_m[i] = 0; time_m[i] = 0; cnt_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
          run_m[i] = 0; det_m[i] = 0; blk_m[i] = 0;
          info_m[i] = 0; idx_m[i] = 0; time_m[i] = 0;
        end else if (det_m[i]) begin
          blk_m[i] = c;
        end else begin
          run_m[i] = c ? run_m[i] + 1 : 0;
          if (run_m[i] >= hold_m[i]) begin
            det_m[i]  = 1;
            blk_m[i]  = 1;
            info_m[i] = e;
            idx_m[i]  = lowest_f(e);
            time_m[i] = ts_m;
            if (cnt_m[i] < 255) cnt_m[i]++;
            run_m[i]  = 0;
          end else begin
            blk_m[i] = 0;
          end
        end
      end
      ts_m = ts_m + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("block[%0d]", i),        64'(blk_o[i]),    64'(blk_m[i]));
      chk($sformatf("sticky[%0d]", i),       64'(sticky_o[i]), 64'(det_m[i]));
      chk($sformatf("info[%0d]", i),         64'(info_o[i]),   64'(info_m[i]));
      chk($sformatf("first_idx[%0d]", i),    64'(idx_o[i]),    64'(idx_m[i]));
      chk($sformatf("detect_time[%0d]", i),  64'(dtime_o[i]),  64'(time_m[i]));
      chk($sformatf("detect_count[%0d]", i), 64'(cnt_o[i]),    64'(cnt_m[i]));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      bit c;
      logic [2:0] e;
      c = cond_f();
      e = eff_f();
      @(posedge clock);
      model_edge(c, e);
      #1;
      check_all();
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic quiet();
    axis_block_sigs = 3'b000; proc_idle_sigs = 2'b00; proc_chan_block_sigs = 2'b00;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; axis_mask = 3'b000; axis_proc_map = 6'b100_011;
    quiet();
    step(2);
    reset = 1'b0;
    step(2);

    // Basic detection: process 0 stalled on channel 0, process 1 idle.
    axis_block_sigs = 3'b001; proc_idle_sigs = 2'b10;
    step(15);
    chk("no_detect_at_15", 64'(sticky_o[0]), 64'd0);
    step(1);
    chk("detect_at_16", 64'(sticky_o[0]), 64'd1);
    chk("detect_block_16", 64'(blk_o[0]), 64'd1);
    chk("detect_info_16", 64'(info_o[0]), 64'd1);
    chk("detect_count_16", 64'(cnt_o[0]), 64'd1);

    // Condition glitch: live flag drops, capture stays.
    proc_idle_sigs = 2'b00;
    step(1);
    chk("glitch_block", 64'(blk_o[0]), 64'd0);
    chk("glitch_sticky", 64'(sticky_o[0]), 64'd1);
    proc_idle_sigs = 2'b10;
    step(2);

    // Clear with condition present, then a fresh window.
    pulse_clear();
    chk("clear_info", 64'(info_o[0]), 64'd0);
    step(16);
    chk("redetect_count", 64'(cnt_o[0]), 64'd2);

    // Broken window: 15 cycles, one gap, then a full window.
    pulse_clear();
    quiet(); step(2);
    axis_block_sigs = 3'b001; proc_idle_sigs = 2'b10;
    step(15);
    proc_idle_sigs = 2'b00;
    step(1);
    proc_idle_sigs = 2'b10;
    step(15);
    chk("rerise_not_yet", 64'(sticky_o[0]), 64'd0);
    step(1);

    // Masked channel never contributes; unmasking allows detection.
    pulse_clear();
    quiet(); step(2);
    axis_block_sigs = 3'b100; proc_chan_block_sigs = 2'b01; axis_mask = 3'b100;
    step(40);
    chk("masked_no_detect", 64'(sticky_o[0]), 64'd0);
    axis_mask = 3'b000;
    step(16);
    chk("unmasked_idx", 64'(idx_o[0]), 64'd2);

    // Clear coinciding with hold completion (16-cycle instance).
    pulse_clear();
    quiet(); step(2);
    axis_block_sigs = 3'b001; proc_idle_sigs = 2'b10;
    step(15);
    pulse_clear();
    step(3);
    quiet(); step(2);

    // Clear on the first condition cycle (1-cycle instance).
    pulse_clear();
    axis_block_sigs = 3'b011; proc_idle_sigs = 2'b10;
    pulse_clear();
    quiet(); step(2);

    // Reset mid-window, timestamp restarts.
    axis_block_sigs = 3'b001; proc_idle_sigs = 2'b10;
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(16);

    // Randomized segments of held input patterns.
    for (int seg = 0; seg < 80; seg++) begin
      axis_block_sigs      = 3'($urandom);
      proc_idle_sigs       = 2'($urandom);
      proc_chan_block_sigs = 2'($urandom);
      axis_mask            = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 7) == 0) axis_proc_map = 6'($urandom);
      clear = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 39) == 0);
      step(1);
      clear = 1'b0;
      reset = 1'b0;
      step($urandom_range(0, 24));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_monitor_param.md
Name: hls_deadlock_monitor_param

Overview:
- Parametrised dataflow deadlock monitor for HLS-generated dataflow regions, e.g. the ADC-to-OPFB chain, with any number of processes and AXI-Stream channels.
- Flags a deadlock when at least one process is blocked on an AXI-Stream channel and every process is idle, channel-blocked or axis-blocked.
- Adds a persistence filter, a runtime channel mask, a runtime process-to-channel map, sticky capture with a timestamp, and a detection counter. Feeds debug ILA and AXI-Lite status registers.

Parameters:
- NUM_PROC, 2, number of dataflow processes (>=1)
- NUM_AXIS, 3, number of monitored AXI-Stream channels (>=1)
- HOLD_CYCLES, 16, consecutive cycles the stop condition must hold before detection (>=1, <=2^16)
- TS_W, 32, width of free-running timestamp counter

Ports:
- clock  in  1  clock
- reset  in  1  reset
- axis_block_sigs  in  NUM_AXIS  per-channel stream-blocked flags
- proc_idle_sigs  in  NUM_PROC  per-process idle
- proc_chan_block_sigs  in  NUM_PROC  per-process internal FIFO/channel block
- axis_proc_map  in  NUM_PROC*NUM_AXIS  bits [p*NUM_AXIS +: NUM_AXIS] = channels owned by process p; quasi-static
- axis_mask  in  NUM_AXIS  1 = ignore channel
- clear  in  1  one-cycle pulse: clear sticky state and capture
- block  out  1  live: detected and condition still true
- block_sticky  out  1  detection latched until clear/reset
- axis_block_info  out  NUM_AXIS  masked axis_block_sigs captured at detection
- first_axis_idx  out  max(1,clog2(NUM_AXIS))  lowest set index of axis_block_info
- detect_time  out  TS_W  timestamp value at detection
- detect_count  out  8  number of detections since reset, saturating at 255

Behaviour:
- Reset is synchronous and active-high: state=MONITOR, hold counter=0, timestamp=0, every output 0.
- Combinational terms:
  - eff[a] = axis_block_sigs[a] & ~axis_mask[a]
  - pax[p] = |(eff & map row p)
  - stop[p] = proc_idle_sigs[p] | proc_chan_block_sigs[p] | pax[p]
  - cond = (|pax) & (&stop)
- The timestamp increments every cycle after reset and wraps at 2^TS_W.
- FSM, hold counter hc (16 bit):
  - MONITOR: if cond and HOLD_CYCLES==1 -> DETECTED. Else if cond -> PENDING with hc=1. Else stay, hc=0.
  - PENDING: if !cond -> MONITOR with hc=0. Else if hc==HOLD_CYCLES-1 -> DETECTED. Else hc++.
  - DETECTED: stays until clear. A cond glitch does not leave it.
- On the transition into DETECTED, registered on the same edge:
  - axis_block_info = eff
  - first_axis_idx = lowest set bit of eff
  - detect_time = timestamp value in the final cond cycle
  - detect_count++ (saturating)
- Latency: the output changes on the edge ending the HOLD_CYCLES-th consecutive cond cycle, and is visible the next cycle.
- block_sticky = (state==DETECTED).
- block is a register: 1 when the next state is DETECTED and cond=1 in the current cycle. It goes low the cycle after cond drops and rises again if cond returns. Captured fields stay frozen throughout.
- clear has priority over everything except reset:
  - From any state: -> MONITOR, hc=0, axis_block_info/first_axis_idx/detect_time=0, block=0.
  - detect_count and the timestamp are not cleared.
  - If clear coincides with hold completion, there is no detection and no count increment.
  - If cond persists after clear, a fresh HOLD_CYCLES window starts the cycle after clear.
- A masked channel never contributes, even if it is in the map.
- A process with an empty map row can only satisfy stop through idle/chan_block.
- All-processes-idle with no axis block gives cond=0, so a normal quiescent design never flags.
- Reset mid-PENDING or in DETECTED returns to the reset state on the next edge.

Test Plan:
- Defaults, map=6'b100_011, mask=0. axis_block_sigs=3'b001, proc_idle=2'b10 held 16 cycles -> block_sticky=1 and block=1 at cycle 17; axis_block_info=3'b001, first_axis_idx=0, detect_count=1, detect_time=timestamp at cycle 16.
- Same stimulus held 15 cycles, then 1 cycle of proc_idle=2'b00, then held 16 cycles -> no detect in the first window; detection 16 cycles after the re-rise.
- axis_block_sigs=3'b100, proc_chan_block=2'b01, mask=3'b100 for 40 cycles -> block_sticky stays 0. Set mask=0 -> detection after 16 cycles, axis_block_info=3'b100, first_axis_idx=2.
- After detection, drop cond for 1 cycle -> block=0 while block_sticky=1 and capture is unchanged. Pulse clear with cond=1 -> all capture fields 0; re-detect 16 cycles later with detect_count=2.
- HOLD_CYCLES=1 -> detection on the first cond cycle. Clear asserted in the same cycle as hold completion -> no detection, detect_count unchanged.
- Reset asserted while in PENDING with hc=10 -> all outputs 0 and timestamp restarts from 0.
